// File: rtl/ddr2_read_scheduler_if.sv
// Requester, memory-command and read-return signal bundle for ddr2_read_scheduler.
// master: the scheduler itself; slave: requesters plus memory interface.
interface ddr2_read_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [27*NUM_REQ-1:0] req_adx;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mem_cmd_valid;
    logic [26:0]           mem_cmd_adx;
    logic                  mem_cmd_ready;
    logic                  has_return_data;
    logic                  get_return_data;
    logic [127:0]          return_data;
    logic [26:0]           return_adx;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [127:0]          rsp_data;
    logic [26:0]           rsp_adx;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic                  adx_err;

    modport master (
        input  req_valid,
        input  req_adx,
        output req_ready,
        output mem_cmd_valid,
        output mem_cmd_adx,
        input  mem_cmd_ready,
        input  has_return_data,
        output get_return_data,
        input  return_data,
        input  return_adx,
        output rsp_valid,
        output rsp_data,
        output rsp_adx,
        input  rsp_ready,
        output adx_err
    );

    modport slave (
        output req_valid,
        output req_adx,
        input  req_ready,
        input  mem_cmd_valid,
        input  mem_cmd_adx,
        output mem_cmd_ready,
        output has_return_data,
        input  get_return_data,
        output return_data,
        output return_adx,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_adx,
        output rsp_ready,
        input  adx_err
    );
endinterface

// File: rtl/ddr2_read_scheduler.sv
// Round-robin DDR2 read scheduler with in-order tag FIFO for return routing.
// Optional DDR2_READ_SCHED_ADX_CHECK_EN: store addresses and flag return mismatches.
module ddr2_read_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input logic clk,
    input logic reset,
    ddr2_read_scheduler_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        C_IDLE,
        C_ISSUE
    } cmd_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_HOLD
    } ret_state_t;

    cmd_state_t c_state, c_next;
    ret_state_t r_state, r_next;

    logic [IW-1:0] prio;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick;
    logic          pick_found;
    logic [26:0]   cmd_adx;
    logic          grant_load;
    logic          push;
    logic          pop;
    logic          capture;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [IW-1:0] tag_mem [TAG_DEPTH];

    logic [IW-1:0] rsp_tag;
    logic [127:0]  rsp_data_q;
    logic [26:0]   rsp_adx_q;

    assign full  = (count == CW'(TAG_DEPTH));
    assign empty = (count == '0);

    // Search from the priority pointer, wrapping at NUM_REQ.
    always_comb begin
        logic [IW-1:0] j;
        pick       = '0;
        pick_found = 1'b0;
        j          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = IW'((int'(prio) + i) % NUM_REQ);
            if (!pick_found && bus.req_valid[j]) begin
                pick_found = 1'b1;
                pick       = j;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_state <= C_IDLE;
            r_state <= R_IDLE;
        end else begin
            c_state <= c_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        c_next            = c_state;
        grant_load        = 1'b0;
        push              = 1'b0;
        bus.mem_cmd_valid = 1'b0;
        bus.req_ready     = '0;
        unique case (c_state)
            C_IDLE: begin
                if (pick_found && !full) begin
                    grant_load = 1'b1;
                    c_next     = C_ISSUE;
                end
            end
            C_ISSUE: begin
                bus.mem_cmd_valid = 1'b1;
                if (bus.mem_cmd_ready) begin
                    push                 = 1'b1;
                    bus.req_ready[grant] = 1'b1;
                    c_next               = C_IDLE;
                end
            end
            default: c_next = C_IDLE;
        endcase
    end

`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
    logic [26:0] adx_mem [TAG_DEPTH];
    logic        err_set;
    logic        err_q;
`endif

    always_comb begin
        r_next              = r_state;
        bus.get_return_data = 1'b0;
        bus.rsp_valid       = '0;
        capture             = 1'b0;
        pop                 = 1'b0;
`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
        err_set             = 1'b0;
`endif
        unique case (r_state)
            R_IDLE: begin
                if (bus.has_return_data) begin
                    bus.get_return_data = 1'b1;
                    r_next              = R_FETCH;
                end
            end
            R_FETCH: begin
                // A return with nothing outstanding has no owner: drop it.
                if (empty) begin
`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
                    err_set = 1'b1;
`endif
                    r_next  = R_IDLE;
                end else begin
                    capture = 1'b1;
                    pop     = 1'b1;
`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
                    err_set = (bus.return_adx != adx_mem[rd_ptr]);
`endif
                    r_next  = R_HOLD;
                end
            end
            R_HOLD: begin
                bus.rsp_valid[rsp_tag] = 1'b1;
                if (bus.rsp_ready[rsp_tag]) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio       <= '0;
            grant      <= '0;
            cmd_adx    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_tag    <= '0;
            rsp_data_q <= '0;
            rsp_adx_q  <= '0;
        end else begin
            if (grant_load) begin
                grant   <= pick;
                cmd_adx <= bus.req_adx[27*pick +: 27];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                prio   <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (capture) begin
                rsp_tag    <= tag_mem[rd_ptr];
                rsp_data_q <= bus.return_data;
                rsp_adx_q  <= bus.return_adx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
            adx_mem[wr_ptr] <= cmd_adx;
`endif
        end
    end

`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.adx_err = err_q;
`else
    assign bus.adx_err = 1'b0;
`endif

    assign bus.mem_cmd_adx = cmd_adx;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_adx     = rsp_adx_q;

endmodule

// File: tb/tb_ddr2_read_scheduler.sv
// Directed bench for ddr2_read_scheduler: arbitration, stall, full FIFO,
// response hold, address check and mid-operation reset.
module tb_ddr2_read_scheduler;
`ifdef DDR2_READ_SCHED_ADX_CHECK_EN
    localparam logic ADX_CHK = 1'b1;
`else
    localparam logic ADX_CHK = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   acc_cnt;

    ddr2_read_scheduler_if #(.NUM_REQ(4)) bus ();

    ddr2_read_scheduler #(
        .NUM_REQ  (4),
        .TAG_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (|bus.req_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_cmd_valid"}, bus.mem_cmd_valid, 0);
        check({tag, "_cmd_adx"}, bus.mem_cmd_adx, 0);
        check({tag, "_get"}, bus.get_return_data, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_rsp_adx"}, bus.rsp_adx, 0);
        check({tag, "_adx_err"}, bus.adx_err, 0);
    endtask

    // exp_hot == 0 means the return must be discarded.
    task automatic do_return(input string tag, input logic [127:0] d,
                             input logic [26:0] a, input logic [3:0] exp_hot,
                             input int hold);
        @(negedge clk);
        bus.has_return_data = 1'b1;
        #1 check({tag, "_get_pulse"}, bus.get_return_data, 1);
        @(negedge clk);
        bus.has_return_data = 1'b0;
        bus.return_data     = d;
        bus.return_adx      = a;
        #1 check({tag, "_get_single"}, bus.get_return_data, 0);
        @(negedge clk);
        bus.return_data = '0;
        bus.return_adx  = '0;
        check({tag, "_rsp_valid"}, bus.rsp_valid, exp_hot);
        if (exp_hot != 4'b0000) begin
            check({tag, "_rsp_data"}, bus.rsp_data, d);
            check({tag, "_rsp_adx"}, bus.rsp_adx, a);
            for (int h = 0; h < hold; h++) begin
                bus.rsp_ready = ~exp_hot;
                @(negedge clk);
                check({tag, "_hold_valid"}, bus.rsp_valid, exp_hot);
                check({tag, "_hold_data"}, bus.rsp_data, d);
                check({tag, "_hold_get"}, bus.get_return_data, 0);
            end
            bus.rsp_ready = exp_hot;
            @(negedge clk);
            bus.rsp_ready = '0;
            check({tag, "_released"}, bus.rsp_valid, 0);
        end
    endtask

    logic [26:0] adr [4];
    int          base;

    initial begin
        n_checks = 0;
        n_errors = 0;
        acc_cnt  = 0;
        adr[0] = 27'h0001000;
        adr[1] = 27'h0002000;
        adr[2] = 27'h0003000;
        adr[3] = 27'h0004000;
        reset               = 1'b1;
        bus.req_valid       = '0;
        bus.req_adx         = '0;
        bus.mem_cmd_ready   = 1'b0;
        bus.has_return_data = 1'b0;
        bus.return_data     = '0;
        bus.return_adx      = '0;
        bus.rsp_ready       = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // All four requesters at once, memory always ready
        reset             = 1'b0;
        bus.req_valid     = 4'hF;
        bus.req_adx       = {adr[3], adr[2], adr[1], adr[0]};
        bus.mem_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_cmd_valid", bus.mem_cmd_valid, 1);
            check("rr_cmd_adx", bus.mem_cmd_adx, adr[i]);
            check("rr_req_ready", bus.req_ready, 4'b0001 << i);
            @(negedge clk);
            check("rr_gap_ready", bus.req_ready, 0);
            check("rr_gap_valid", bus.mem_cmd_valid, 0);
        end
        bus.req_valid = '0;

        do_return("ret0", 128'h11111111_22222222_33333333_44444444,
                  adr[0], 4'b0001, 0);
        do_return("ret1", 128'h55555555_66666666_77777777_88888888,
                  adr[1], 4'b0010, 0);
        do_return("ret2", 128'h0123456789ABCDEF_0123456789ABCDEF,
                  adr[2], 4'b0100, 3);
        do_return("ret3", 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC,
                  adr[3], 4'b1000, 0);
        check("ret_adx_err", bus.adx_err, 0);

        // Memory stalls for five cycles
        @(negedge clk);
        bus.mem_cmd_ready = 1'b0;
        bus.req_valid     = 4'b0001;
        bus.req_adx       = {27'h0, 27'h0, 27'h0, 27'h0000100};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", bus.mem_cmd_valid, 1);
            check("stall_adx", bus.mem_cmd_adx, 27'h0000100);
            check("stall_ready", bus.req_ready, 0);
        end
        bus.mem_cmd_ready = 1'b1;
        #1 check("stall_release", bus.req_ready, 4'b0001);
        bus.req_valid = '0;

        do_return("mis", 128'hDEADBEEF, 27'h0000104, 4'b0001, 0);
        check("mis_adx_err", bus.adx_err, ADX_CHK);
        repeat (3) @(negedge clk);
        check("mis_adx_err_sticky", bus.adx_err, ADX_CHK);

        // Nine reads from requester 1, no returns: eight fit
        base          = acc_cnt;
        bus.req_valid = 4'b0010;
        bus.req_adx   = {27'h0, 27'h0, 27'h0000200, 27'h0};
        repeat (24) @(negedge clk);
        check("full_accepts", acc_cnt - base, 8);
        check("full_cmd_valid", bus.mem_cmd_valid, 0);
        check("full_req_ready", bus.req_ready, 0);
        do_return("full_ret", 128'hCAFE, 27'h0000200, 4'b0010, 0);
        for (int k = 0; k < 8; k++) begin
            if (acc_cnt - base == 9) break;
            @(negedge clk);
        end
        check("ninth_accept", acc_cnt - base, 9);
        bus.req_valid = '0;

        // Reset with tags outstanding
        @(negedge clk);
        reset = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_return("drop", 128'hBAD, 27'h0000200, 4'b0000, 0);
        check("drop_adx_err", bus.adx_err, ADX_CHK);

        @(negedge clk);
        bus.req_valid = 4'hF;
        bus.req_adx   = {adr[3], adr[2], adr[1], adr[0]};
        @(negedge clk);
        check("post_reset_grant", bus.req_ready, 4'b0001);
        check("post_reset_adx", bus.mem_cmd_adx, adr[0]);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
